nibble_exec_unit: RTL and testbench
===================================

// Module: nibble_exec_unit
// PURPOSE
// - Datapath-side responder to the nibble processor's central control FSM: takes the 2-bit control
//   code, fetches instruction bytes from program memory over a req/ack handshake, executes them on a
//   4-bit accumulator and returns the decoded opcode op[1:0] to the controller.
// - Sits between central control and program memory; the controller holds ctrl until ready pulses.
// PARAMETERS
// - ADDR_W    4     program-counter / memory address width; PC wraps modulo 2**ADDR_W
// - RESET_PC  0     PC value loaded on reset (ADDR_W bits)
// PORTS
// - clk        in   1       system clock; single clock domain, rising edge
// - reset      in   1       synchronous, active-high; sampled on rising clk
// - ctrl       in   2       10=FETCH, 01=EXEC, 00=IDLE, 11=reserved (treated as IDLE)
// - op         out  2       ir[7:6], combinational from IR: 00=NOP, 01=ALU, 1x=HALT
// - ready      out  1       one-cycle pulse: requested FETCH/EXEC step completed
// - halted     out  1       sticky; set by executing a HALT-class op; cleared only by reset
// - mem_req    out  1       program-memory read request (registered)
// - mem_addr   out  ADDR_W  read address = PC, stable while mem_req=1
// - mem_ack    in   1       memory read done; mem_rdata valid in the same cycle
// - mem_rdata  in   8       instruction byte {op[1:0], func[1:0], imm[3:0]}
// - acc        out  4       accumulator
// - carry      out  1       carry/borrow flag
// - pc         out  ADDR_W  program counter
// BEHAVIOUR
// - Reset: pc=RESET_PC, ir=8'h00 (op=00), acc=0, carry=0, mem_req=0, ready=0, halted=0, state=IDLE.
//   Reset mid-REQ drops mem_req at that edge; no pc/ir update from a coincident mem_ack.
// - FSM states IDLE, REQ, EXEC, HALTED:
//   IDLE  : ctrl=FETCH -> REQ (mem_req=1 next cycle); ctrl=EXEC -> EXEC; else stay.
//   REQ   : mem_req=1; on mem_ack: ir<=mem_rdata, pc<=pc+1 (wrap), mem_req<=0, ready<=1, -> IDLE.
//           No ack -> stay; ctrl changes ignored (no abort).
//   EXEC  : one cycle; op=00 no change; op=01 ALU update; op=1x halted<=1, -> HALTED.
//           ready<=1 for op 00/01 (-> IDLE); no ready pulse on HALT.
//   HALTED: ignore ctrl and mem_ack, mem_req=0, hold all state until reset.
// - Latency: zero-wait memory, FETCH seen in IDLE at cycle 0 -> mem_req cycle 1 -> ir/pc/ready at
//   cycle 2. EXEC seen at cycle 0 -> acc/carry/ready updated at cycle 2 (IDLE->EXEC->IDLE).
// - ready is exactly one cycle wide; a ctrl still asserted in the cycle ready is high is a new request.
// - mem_ack outside REQ is ignored.
// - ALU (func = ir[5:4], imm = ir[3:0], 5-bit internal sum):
//   00 LOAD acc<=imm, carry unchanged; 01 ADD {carry,acc}<=acc+imm;
//   10 SUB acc<=acc-imm mod 16, carry<=borrow (acc<imm); 11 XOR acc<=acc^imm, carry unchanged.
// STRUCTURE
// - Shared package nibble_pkg: ctrl codes (CTRL_IDLE/FETCH/EXEC), op codes (OP_NOP/ALU/HALT),
//   func codes, instruction field positions, exec-unit state encoding.
// - One sub-module: nibble_alu (combinational: acc, imm, func, carry_in -> acc_next, carry_next).
// - Top holds the FSM, PC, IR, accumulator/carry registers, and the handshake logic.
// TESTING
// - Reset then FETCH, ack same cycle as req, rdata=8'h45 -> ir=45, op=01, pc=1, ready pulse cycle 2.
// - FETCH with ack delayed 3 cycles -> mem_req/mem_addr held stable 4 cycles, ctrl toggles ignored,
//   a single ready pulse.
// - EXEC sequence LOAD 9 (8'h49), ADD 9 (8'h59) -> acc=2, carry=1; SUB 3 (8'h63) -> acc=F, carry=1;
//   XOR 5 (8'h75) -> acc=A, carry=1.
// - PC wrap: ADDR_W=4, 16 consecutive fetches from pc=F -> pc goes F->0; mem_addr=F on 1st request.
// - HALT: fetch 8'h80 then EXEC -> halted=1, no ready pulse; later FETCH/EXEC and spurious mem_ack
//   cause no change.
// - Reset asserted while in REQ with mem_ack=1 -> next cycle mem_req=0, pc=RESET_PC, ir=0,
//   halted=0.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble processor exec unit: control/op/func codes,
// instruction field layout and exec-unit state encoding.
package nibble_pkg;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_EXEC  = 2'b01;
  localparam logic [1:0] CTRL_FETCH = 2'b10;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;

  localparam logic [1:0] FUNC_LOAD = 2'b00;
  localparam logic [1:0] FUNC_ADD  = 2'b01;
  localparam logic [1:0] FUNC_SUB  = 2'b10;
  localparam logic [1:0] FUNC_XOR  = 2'b11;

  localparam int IR_OP_LSB   = 6;
  localparam int IR_FUNC_LSB = 4;
  localparam int IR_IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALTED = 2'b11
  } exec_state_e;

  function automatic logic [1:0] ir_op(input logic [7:0] ir);
    return ir[IR_OP_LSB +: 2];
  endfunction

  function automatic logic [1:0] ir_func(input logic [7:0] ir);
    return ir[IR_FUNC_LSB +: 2];
  endfunction

  function automatic logic [3:0] ir_imm(input logic [7:0] ir);
    return ir[IR_IMM_LSB +: 4];
  endfunction

  // Both 10 and 11 are HALT-class, so only the top op bit matters.
  function automatic logic is_halt(input logic [1:0] op);
    return (op & OP_HALT) != 2'b00;
  endfunction

endpackage

// File: rtl/nibble_alu.sv
// Combinational 4-bit accumulator ALU: LOAD / ADD / SUB / XOR on acc and imm.
module nibble_alu
  import nibble_pkg::*;
(
  input  logic [3:0] acc,
  input  logic [3:0] imm,
  input  logic [1:0] func,
  input  logic       carry_in,
  output logic [3:0] acc_next,
  output logic       carry_next
);

  logic [4:0] sum;

  always_comb begin
    sum        = {1'b0, acc} + {1'b0, imm};
    acc_next   = acc;
    carry_next = carry_in;
    case (func)
      FUNC_LOAD: acc_next = imm;
      FUNC_ADD:  {carry_next, acc_next} = sum;
      FUNC_SUB: begin
        acc_next   = acc - imm;
        carry_next = (acc < imm);
      end
      FUNC_XOR:  acc_next = acc ^ imm;
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_exec_unit.sv
// Exec unit answering the central controller: fetches instruction bytes over a
// req/ack memory handshake and executes them on a 4-bit accumulator.
module nibble_exec_unit
  import nibble_pkg::*;
#(
  parameter int              ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ctrl,
  output logic [1:0]        op,
  output logic              ready,
  output logic              halted,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        acc,
  output logic              carry,
  output logic [ADDR_W-1:0] pc
);

  exec_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [3:0]        acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              halted_q, halted_d;
  logic              ready_q, ready_d;
  logic              mem_req_q, mem_req_d;

  logic [3:0]        alu_acc;
  logic              alu_carry;

  nibble_alu u_alu (
    .acc        (acc_q),
    .imm        (ir_imm(ir_q)),
    .func       (ir_func(ir_q)),
    .carry_in   (carry_q),
    .acc_next   (alu_acc),
    .carry_next (alu_carry)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    halted_d  = halted_q;
    ready_d   = 1'b0;
    mem_req_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl == CTRL_FETCH) begin
          state_d   = ST_REQ;
          mem_req_d = 1'b1;
        end else if (ctrl == CTRL_EXEC) begin
          state_d = ST_EXEC;
        end
      end
      // Once a fetch is issued it runs to completion; ctrl is not looked at.
      ST_REQ: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_halt(ir_op(ir_q))) begin
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end else begin
          if (ir_op(ir_q) == OP_ALU) begin
            acc_d   = alu_acc;
            carry_d = alu_carry;
          end
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      acc_q     <= 4'h0;
      carry_q   <= 1'b0;
      halted_q  <= 1'b0;
      ready_q   <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      halted_q  <= halted_d;
      ready_q   <= ready_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign op       = ir_op(ir_q);
  assign ready    = ready_q;
  assign halted   = halted_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_nibble_exec_unit.sv
// Randomized self-checking bench for nibble_exec_unit against an instruction-level model.
module tb_nibble_exec_unit;
  import nibble_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    ctrl;
  logic [1:0]    op;
  logic          ready, halted, mem_req, mem_ack, carry;
  logic [AW-1:0] mem_addr, pc;
  logic [7:0]    mem_rdata;
  logic [3:0]    acc;

  int n_chk  = 0;
  int n_fail = 0;

  // architectural model
  int m_pc, m_ir, m_acc, m_carry, m_halted;

  nibble_exec_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .op        (op),
    .ready     (ready),
    .halted    (halted),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .acc       (acc),
    .carry     (carry),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_op"},     32'(op),     32'((m_ir >> 6) & 3));
    check({tag, "_pc"},     32'(pc),     32'(m_pc));
    check({tag, "_acc"},    32'(acc),    32'(m_acc));
    check({tag, "_carry"},  32'(carry),  32'(m_carry));
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_acc = 0; m_carry = 0; m_halted = 0;
  endtask

  task automatic model_exec();
    int opc, fn, imm, s;
    opc = (m_ir >> 6) & 3;
    fn  = (m_ir >> 4) & 3;
    imm = m_ir & 15;
    if (opc >= 2) m_halted = 1;
    else if (opc == 1) begin
      case (fn)
        0: m_acc = imm;
        1: begin s = m_acc + imm; m_acc = s % 16; m_carry = (s >= 16) ? 1 : 0; end
        2: begin m_carry = (m_acc < imm) ? 1 : 0; m_acc = (m_acc - imm + 16) % 16; end
        default: m_acc = m_acc ^ imm;
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ctrl = CTRL_IDLE; mem_ack = 1'b0; mem_rdata = 8'h00;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_fetch(input logic [7:0] rd, input int dly);
    ctrl = CTRL_FETCH;
    @(negedge clk);
    for (int i = 0; i <= dly; i++) begin
      check("req_hi",   32'(mem_req),  32'd1);
      check("req_addr", 32'(mem_addr), 32'(m_pc));
      check("req_rdy",  32'(ready),    32'd0);
      ctrl      = 2'($urandom_range(0, 3));
      mem_ack   = (i == dly);
      mem_rdata = (i == dly) ? rd : 8'($urandom);
      @(negedge clk);
    end
    m_ir = rd;
    m_pc = (m_pc + 1) % (1 << AW);
    ctrl      = CTRL_IDLE;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = 8'($urandom);
    check("fetch_rdy", 32'(ready),   32'd1);
    check("fetch_req", 32'(mem_req), 32'd0);
    check_arch("fetch");
    @(negedge clk);
    mem_ack = 1'b0;
    check("fetch_rdy_drop", 32'(ready), 32'd0);
    check("idle_ack_pc",    32'(pc),    32'(m_pc));
    check("idle_ack_op",    32'(op),    32'((m_ir >> 6) & 3));
  endtask

  task automatic do_exec();
    ctrl = CTRL_EXEC;
    @(negedge clk);
    ctrl = CTRL_IDLE;
    check("exec_rdy_early", 32'(ready), 32'd0);
    model_exec();
    @(negedge clk);
    check("exec_rdy", 32'(ready), m_halted ? 32'd0 : 32'd1);
    check_arch("exec");
    @(negedge clk);
    check("exec_rdy_drop", 32'(ready), 32'd0);
  endtask

  initial begin
    logic [7:0] seq [4];
    reset = 1'b1; ctrl = CTRL_IDLE; mem_ack = 1'b0; mem_rdata = 8'h00;
    do_reset();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_rdy", 32'(ready),   32'd0);
    check_arch("rst");

    do_fetch(8'h45, 0);
    check("first_pc", 32'(pc), 32'd1);
    check("first_op", 32'(op), 32'(OP_ALU));

    seq[0] = 8'h49; seq[1] = 8'h59; seq[2] = 8'h63; seq[3] = 8'h75;
    for (int i = 0; i < 4; i++) begin
      do_fetch(seq[i], (i == 0) ? 3 : i);
      do_exec();
    end
    check("seq_acc",   32'(acc),   32'hA);
    check("seq_carry", 32'(carry), 32'd1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) do_fetch(8'($urandom_range(0, 127)), $urandom_range(0, 3));
      do_exec();
    end

    while (m_pc != (1 << AW) - 1) do_fetch(8'($urandom_range(0, 127)), 0);
    check("wrap_start", 32'(mem_addr), 32'hF);
    for (int i = 0; i < 16; i++) do_fetch(8'($urandom_range(0, 127)), $urandom_range(0, 1));
    check("wrap_end", 32'(pc), 32'hF);

    do_fetch(8'h80, 1);
    do_exec();
    check("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 8; i++) begin
      ctrl      = 2'($urandom_range(0, 3));
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      @(negedge clk);
      check("halt_req", 32'(mem_req), 32'd0);
      check("halt_rdy", 32'(ready),   32'd0);
      check_arch("halt_hold");
    end

    do_reset();
    check_arch("rst2");
    do_fetch(8'h3C, 0);
    do_fetch(8'h12, 0);
    ctrl = CTRL_FETCH;
    @(negedge clk);
    check("mid_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'hC5; reset = 1'b1; ctrl = CTRL_IDLE;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b0;
    model_reset();
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_rdy", 32'(ready),   32'd0);
    check_arch("midrst");

    do_fetch(8'h47, 2);
    do_exec();
    check("post_acc", 32'(acc), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
